branch_resolve_unit: RTL and testbench
======================================

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 Parameter DEPTH, default 4: queue entries; power of two, at least 2.
REQ-002 Parameter TAG_W, default 3: ROB tag width.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset; asynchronous, active-high.
REQ-005 disp_valid  in  1  dispatch a branch this cycle.
REQ-006 disp_ready  out  1  queue can accept; equals not full.
REQ-007 disp_funct3  in  3  RV32I branch funct3 (beq 000, bne 001, blt 100, bge 101, bltu 110, bgeu 111).
REQ-008 disp_pc, disp_imm  in  32 each  branch PC and sign-extended B-immediate.
REQ-009 disp_rob_tag  in  TAG_W  ROB tag of the branch.
REQ-010 disp_pred_taken  in  1  fetch-time prediction.
REQ-011 disp_src{1,2}_valid  in  1  the operand value is present.
REQ-012 disp_src{1,2}_val  in  32  the operand value; disp_src{1,2}_tag  in  TAG_W  the producer tag when the operand is not valid.
REQ-013 cdb_valid  in  1; cdb_tag  in  TAG_W; cdb_data  in  32: common data bus broadcast.
REQ-014 flush  in  1  synchronous squash of all queued branches.
REQ-015 res_valid  out  1  registered resolution pulse.
REQ-016 res_rob_tag  out  TAG_W; res_taken  out  1; res_target  out  32; res_mispredict  out  1.

Function
REQ-017 The queue SHALL be a circular FIFO of DEPTH entries with head and tail pointers and an occupancy count.
- Each entry holds: funct3, pc, imm, tag, pred, and for each source: valid, value, tag.
REQ-018 Enqueue SHALL occur when disp_valid and disp_ready; disp_valid with disp_ready low SHALL be ignored, and disp_ready SHALL be independent of disp_valid.
REQ-019 Each cycle, every occupied entry with an invalid source whose tag equals cdb_tag while cdb_valid SHALL capture cdb_data and set that source valid.
REQ-020 A dispatch in the same cycle as a matching CDB broadcast SHALL enqueue that source already valid, holding cdb_data.
REQ-021 Issue SHALL be strictly in order: only the head issues, and only when both its sources are valid as stored in registers.
- A CDB capture makes an entry eligible in the following cycle.
REQ-022 On issue, the head SHALL dequeue, and one cycle later res_valid SHALL be 1 with:
- taken per funct3 (signed compare for blt/bge, unsigned for bltu/bgeu);
- target = pc+imm if taken, else pc+4, both mod 2^32;
- mispredict = taken XOR pred.
REQ-023 An invalid funct3 (010, 011) SHALL resolve as not-taken, target pc+4.
REQ-024 Simultaneous enqueue and dequeue when full SHALL be refused: disp_ready reflects the registered count.
- Simultaneous enqueue and dequeue when not full SHALL keep the count unchanged.
REQ-025 Pointers SHALL wrap modulo DEPTH.
REQ-026 flush SHALL, at the next edge, empty the queue and force res_valid to 0, with priority over dispatch, issue and CDB capture in that cycle.
REQ-027 res_valid SHALL be a single-cycle pulse per issued branch; other res_* outputs are don't-care when res_valid is 0.
REQ-028 Maximum throughput SHALL be one resolution per cycle.

Reset
REQ-029 While rst is high: queue empty, pointers 0, count 0, all entry valid bits 0, res_valid 0, res_taken 0, res_mispredict 0, res_target 0, res_rob_tag 0, disp_ready 1.
REQ-030 Deasserting rst mid-operation SHALL leave no queued entries; the first legal dispatch is accepted in the first cycle after deassertion.

Verification
REQ-031 Dispatch beq with pc=0x100, imm=0x20, src1=src2=5, both valid, pred=0 -> two edges later: res_valid=1, taken=1, target=0x120, mispredict=1.
REQ-032 Dispatch blt with src1=0xFFFFFFFF, src2=1, plus bltu with the same operands, back-to-back -> resolutions in order: blt taken; bltu not taken, target pc+4.
REQ-033 Dispatch bne with src1 waiting on tag 3; in a later cycle drive cdb_valid with tag=3, data=7, src2=7 -> no resolution before the capture; after it, taken=0.
REQ-034 Fill DEPTH entries whose operands are all pending -> disp_ready=0 and a fifth dispatch is ignored; broadcast the tags -> all DEPTH entries resolve in FIFO order with tags preserved across pointer wrap.
REQ-035 Assert flush together with disp_valid and a ready head -> next cycle the queue is empty, res_valid=0 and disp_ready=1.
REQ-036 Assert rst asynchronously between edges with 3 entries queued -> outputs reach reset values immediately, and no stale resolution appears after release.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//   In-order branch resolution queue for an RV32I out-of-order core.
//   Dispatched branches wait in a circular FIFO until both operands are
//   present. Operands come either from dispatch or from CDB snooping. The
//   head entry issues once both of its stored operands are valid. Its
//   outcome (taken, target, mispredict) is registered and presented for
//   exactly one cycle.
//
// Ports
//   clk, rst                    clock, async active-high reset
//   disp_valid / disp_ready     dispatch handshake (ready = queue not full)
//   disp_funct3, disp_pc,       branch kind, PC, sign-extended B-immediate
//   disp_imm
//   disp_rob_tag                ROB tag carried through to the resolution
//   disp_pred_taken             fetch-time prediction
//   disp_src{1,2}_valid/val/tag operand value, or producer tag if pending
//   cdb_valid, cdb_tag, cdb_data
//                               result broadcast snooped by pending operands
//   flush                       squash everything queued (synchronous)
//   res_valid, res_rob_tag, res_taken, res_target, res_mispredict
//                               registered resolution, one-cycle pulse
module branch_resolve_unit #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  logic [2:0]       disp_funct3,
  input  logic [31:0]      disp_pc,
  input  logic [31:0]      disp_imm,
  input  logic [TAG_W-1:0] disp_rob_tag,
  input  logic             disp_pred_taken,
  input  logic             disp_src1_valid,
  input  logic [31:0]      disp_src1_val,
  input  logic [TAG_W-1:0] disp_src1_tag,
  input  logic             disp_src2_valid,
  input  logic [31:0]      disp_src2_val,
  input  logic [TAG_W-1:0] disp_src2_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_data,
  input  logic             flush,
  output logic             res_valid,
  output logic [TAG_W-1:0] res_rob_tag,
  output logic             res_taken,
  output logic [31:0]      res_target,
  output logic             res_mispredict
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic [DEPTH-1:0] e_valid;
  logic [DEPTH-1:0] e_pred;
  logic [DEPTH-1:0] e_s1v;
  logic [DEPTH-1:0] e_s2v;
  logic [2:0]       e_f3    [DEPTH];
  logic [31:0]      e_pc    [DEPTH];
  logic [31:0]      e_imm   [DEPTH];
  logic [TAG_W-1:0] e_tag   [DEPTH];
  logic [31:0]      e_s1    [DEPTH];
  logic [TAG_W-1:0] e_s1tag [DEPTH];
  logic [31:0]      e_s2    [DEPTH];
  logic [TAG_W-1:0] e_s2tag [DEPTH];

  logic        enq;
  logic        deq;
  logic        in_s1v;
  logic        in_s2v;
  logic [31:0] in_s1;
  logic [31:0] in_s2;
  logic        h_taken;
  logic [31:0] h_target;

  // Ready comes only from the registered count, so a full queue refuses a
  // dispatch even when the head is dequeuing in the same cycle.
  assign disp_ready = (count != CNT_W'(DEPTH));
  assign enq        = disp_valid & disp_ready & ~flush;

  // Eligibility looks only at stored operand-valid bits. A CDB capture
  // therefore makes the head eligible one cycle later.
  assign deq = e_valid[head] & e_s1v[head] & e_s2v[head] & ~flush;

  // Same-cycle forwarding: a broadcast matching a pending dispatch operand
  // is written into the new entry as already valid.
  assign in_s1v = disp_src1_valid | (cdb_valid & (cdb_tag == disp_src1_tag));
  assign in_s2v = disp_src2_valid | (cdb_valid & (cdb_tag == disp_src2_tag));
  assign in_s1  = disp_src1_valid ? disp_src1_val : cdb_data;
  assign in_s2  = disp_src2_valid ? disp_src2_val : cdb_data;

  always_comb begin
    logic [31:0] a;
    logic [31:0] b;
    a = e_s1[head];
    b = e_s2[head];
    h_taken = 1'b0;
    case (e_f3[head])
      3'b000:  h_taken = (a == b);
      3'b001:  h_taken = (a != b);
      3'b100:  h_taken = ($signed(a) <  $signed(b));
      3'b101:  h_taken = ($signed(a) >= $signed(b));
      3'b110:  h_taken = (a <  b);
      3'b111:  h_taken = (a >= b);
      default: h_taken = 1'b0;   // 010/011 are not branches: fall through
    endcase
    h_target = h_taken ? (e_pc[head] + e_imm[head]) : (e_pc[head] + 32'd4);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      e_valid <= '0;
      e_pred  <= '0;
      e_s1v   <= '0;
      e_s2v   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        e_f3[i]    <= '0;
        e_pc[i]    <= '0;
        e_imm[i]   <= '0;
        e_tag[i]   <= '0;
        e_s1[i]    <= '0;
        e_s1tag[i] <= '0;
        e_s2[i]    <= '0;
        e_s2tag[i] <= '0;
      end
    end else if (flush) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      e_valid <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (e_valid[i] && cdb_valid) begin
          if (!e_s1v[i] && (e_s1tag[i] == cdb_tag)) begin
            e_s1v[i] <= 1'b1;
            e_s1[i]  <= cdb_data;
          end
          if (!e_s2v[i] && (e_s2tag[i] == cdb_tag)) begin
            e_s2v[i] <= 1'b1;
            e_s2[i]  <= cdb_data;
          end
        end
      end

      // The tail slot is always unoccupied when enq is high, so these
      // writes never collide with the snoop updates above.
      if (enq) begin
        e_valid[tail] <= 1'b1;
        e_f3[tail]    <= disp_funct3;
        e_pc[tail]    <= disp_pc;
        e_imm[tail]   <= disp_imm;
        e_tag[tail]   <= disp_rob_tag;
        e_pred[tail]  <= disp_pred_taken;
        e_s1v[tail]   <= in_s1v;
        e_s1[tail]    <= in_s1;
        e_s1tag[tail] <= disp_src1_tag;
        e_s2v[tail]   <= in_s2v;
        e_s2[tail]    <= in_s2;
        e_s2tag[tail] <= disp_src2_tag;
        tail          <= tail + PTR_W'(1);
      end

      if (deq) begin
        e_valid[head] <= 1'b0;
        head          <= head + PTR_W'(1);
      end

      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid      <= 1'b0;
      res_rob_tag    <= '0;
      res_taken      <= 1'b0;
      res_target     <= '0;
      res_mispredict <= 1'b0;
    end else if (flush) begin
      res_valid <= 1'b0;
    end else begin
      res_valid <= deq;
      if (deq) begin
        res_rob_tag    <= e_tag[head];
        res_taken      <= h_taken;
        res_target     <= h_target;
        res_mispredict <= h_taken ^ e_pred[head];
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

  localparam int DEPTH = 4;
  localparam int TAG_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             disp_valid;
  logic             disp_ready;
  logic [2:0]       disp_funct3;
  logic [31:0]      disp_pc;
  logic [31:0]      disp_imm;
  logic [TAG_W-1:0] disp_rob_tag;
  logic             disp_pred_taken;
  logic             disp_src1_valid;
  logic [31:0]      disp_src1_val;
  logic [TAG_W-1:0] disp_src1_tag;
  logic             disp_src2_valid;
  logic [31:0]      disp_src2_val;
  logic [TAG_W-1:0] disp_src2_tag;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_data;
  logic             flush;
  logic             res_valid;
  logic [TAG_W-1:0] res_rob_tag;
  logic             res_taken;
  logic [31:0]      res_target;
  logic             res_mispredict;

  int tests  = 0;
  int failed = 0;

  branch_resolve_unit #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .disp_valid      (disp_valid),
    .disp_ready      (disp_ready),
    .disp_funct3     (disp_funct3),
    .disp_pc         (disp_pc),
    .disp_imm        (disp_imm),
    .disp_rob_tag    (disp_rob_tag),
    .disp_pred_taken (disp_pred_taken),
    .disp_src1_valid (disp_src1_valid),
    .disp_src1_val   (disp_src1_val),
    .disp_src1_tag   (disp_src1_tag),
    .disp_src2_valid (disp_src2_valid),
    .disp_src2_val   (disp_src2_val),
    .disp_src2_tag   (disp_src2_tag),
    .cdb_valid       (cdb_valid),
    .cdb_tag         (cdb_tag),
    .cdb_data        (cdb_data),
    .flush           (flush),
    .res_valid       (res_valid),
    .res_rob_tag     (res_rob_tag),
    .res_taken       (res_taken),
    .res_target      (res_target),
    .res_mispredict  (res_mispredict)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  f3;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] s1;
    logic [31:0] s2;
    logic        pred;
    logic        taken;
    logic [31:0] target;
    logic        misp;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_valid      = 1'b0;
    disp_funct3     = 3'b000;
    disp_pc         = '0;
    disp_imm        = '0;
    disp_rob_tag    = '0;
    disp_pred_taken = 1'b0;
    disp_src1_valid = 1'b0;
    disp_src1_val   = '0;
    disp_src1_tag   = '0;
    disp_src2_valid = 1'b0;
    disp_src2_val   = '0;
    disp_src2_tag   = '0;
    cdb_valid       = 1'b0;
    cdb_tag         = '0;
    cdb_data        = '0;
    flush           = 1'b0;
  endtask

  task automatic drive(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                       input logic [2:0] tag, input logic pred,
                       input logic s1v, input logic [31:0] s1, input logic [2:0] s1t,
                       input logic s2v, input logic [31:0] s2, input logic [2:0] s2t);
    disp_valid      = 1'b1;
    disp_funct3     = f3;
    disp_pc         = pc;
    disp_imm        = imm;
    disp_rob_tag    = tag;
    disp_pred_taken = pred;
    disp_src1_valid = s1v;
    disp_src1_val   = s1;
    disp_src1_tag   = s1t;
    disp_src2_valid = s2v;
    disp_src2_val   = s2;
    disp_src2_tag   = s2t;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_res_valid"},  32'(res_valid), 32'd0);
    check({pfx, "_res_taken"},  32'(res_taken), 32'd0);
    check({pfx, "_res_misp"},   32'(res_mispredict), 32'd0);
    check({pfx, "_res_target"}, res_target, 32'd0);
    check({pfx, "_res_tag"},    32'(res_rob_tag), 32'd0);
    check({pfx, "_disp_ready"}, 32'(disp_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [2:0]  got_tag [4];
    logic [31:0] got_tgt [4];

    vecs[0]  = '{f3:3'b000, pc:32'h100,      imm:32'h20,       s1:32'd5,        s2:32'd5,        pred:1'b0, taken:1'b1, target:32'h120,      misp:1'b1};
    vecs[1]  = '{f3:3'b001, pc:32'h100,      imm:32'h20,       s1:32'd5,        s2:32'd5,        pred:1'b0, taken:1'b0, target:32'h104,      misp:1'b0};
    vecs[2]  = '{f3:3'b100, pc:32'h200,      imm:32'h40,       s1:32'hFFFFFFFF, s2:32'd1,        pred:1'b1, taken:1'b1, target:32'h240,      misp:1'b0};
    vecs[3]  = '{f3:3'b110, pc:32'h200,      imm:32'h40,       s1:32'hFFFFFFFF, s2:32'd1,        pred:1'b1, taken:1'b0, target:32'h204,      misp:1'b1};
    vecs[4]  = '{f3:3'b101, pc:32'h300,      imm:32'hFFFFFFF0, s1:32'd1,        s2:32'hFFFFFFFF, pred:1'b0, taken:1'b1, target:32'h2F0,      misp:1'b1};
    vecs[5]  = '{f3:3'b111, pc:32'h300,      imm:32'hFFFFFFF0, s1:32'd1,        s2:32'hFFFFFFFF, pred:1'b0, taken:1'b0, target:32'h304,      misp:1'b0};
    vecs[6]  = '{f3:3'b010, pc:32'h400,      imm:32'h8,        s1:32'd0,        s2:32'd0,        pred:1'b1, taken:1'b0, target:32'h404,      misp:1'b1};
    vecs[7]  = '{f3:3'b011, pc:32'h400,      imm:32'h8,        s1:32'd0,        s2:32'd0,        pred:1'b0, taken:1'b0, target:32'h404,      misp:1'b0};
    vecs[8]  = '{f3:3'b101, pc:32'hFFFFFFFC, imm:32'h8,        s1:32'd7,        s2:32'd7,        pred:1'b1, taken:1'b1, target:32'h4,        misp:1'b0};
    vecs[9]  = '{f3:3'b000, pc:32'hFFFFFFFC, imm:32'h8,        s1:32'd3,        s2:32'd4,        pred:1'b0, taken:1'b0, target:32'h0,        misp:1'b0};
    vecs[10] = '{f3:3'b110, pc:32'h10,       imm:32'h7FFFFFF0, s1:32'd0,        s2:32'd1,        pred:1'b1, taken:1'b1, target:32'h80000000, misp:1'b0};
    vecs[11] = '{f3:3'b100, pc:32'h20,       imm:32'h4,        s1:32'h80000000, s2:32'h7FFFFFFF, pred:1'b0, taken:1'b1, target:32'h24,       misp:1'b1};
    vecs[12] = '{f3:3'b001, pc:32'h500,      imm:32'h10,       s1:32'd1,        s2:32'd2,        pred:1'b1, taken:1'b1, target:32'h510,      misp:1'b0};

    idle();
    rst = 1'b1;
    #12;
    check_reset_outputs("reset");
    step();
    rst = 1'b0;

    // Single-branch vectors, one at a time; resolution two edges after dispatch.
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].f3, vecs[i].pc, vecs[i].imm, 3'(i), vecs[i].pred,
            1'b1, vecs[i].s1, 3'd0, 1'b1, vecs[i].s2, 3'd0);
      step();
      idle();
      check($sformatf("vec%0d_early", i), 32'(res_valid), 32'd0);
      step();
      check($sformatf("vec%0d_valid", i),  32'(res_valid), 32'd1);
      check($sformatf("vec%0d_taken", i),  32'(res_taken), 32'(vecs[i].taken));
      check($sformatf("vec%0d_target", i), res_target, vecs[i].target);
      check($sformatf("vec%0d_misp", i),   32'(res_mispredict), 32'(vecs[i].misp));
      check($sformatf("vec%0d_tag", i),    32'(res_rob_tag), 32'(i % 8));
      step();
      check($sformatf("vec%0d_pulse", i),  32'(res_valid), 32'd0);
    end

    // Back-to-back blt then bltu with identical operands.
    drive(3'b100, 32'h600, 32'h80, 3'd1, 1'b0, 1'b1, 32'hFFFFFFFF, 3'd0, 1'b1, 32'd1, 3'd0);
    step();
    drive(3'b110, 32'h700, 32'h80, 3'd2, 1'b0, 1'b1, 32'hFFFFFFFF, 3'd0, 1'b1, 32'd1, 3'd0);
    step();
    idle();
    check("b2b_blt_valid",  32'(res_valid), 32'd1);
    check("b2b_blt_tag",    32'(res_rob_tag), 32'd1);
    check("b2b_blt_taken",  32'(res_taken), 32'd1);
    check("b2b_blt_target", res_target, 32'h680);
    step();
    check("b2b_bltu_valid",  32'(res_valid), 32'd1);
    check("b2b_bltu_tag",    32'(res_rob_tag), 32'd2);
    check("b2b_bltu_taken",  32'(res_taken), 32'd0);
    check("b2b_bltu_target", res_target, 32'h704);
    step();
    check("b2b_done", 32'(res_valid), 32'd0);

    // bne waiting on tag 3; resolves only after the capture, one cycle late.
    drive(3'b001, 32'h800, 32'h40, 3'd5, 1'b1, 1'b0, 32'd0, 3'd3, 1'b1, 32'd7, 3'd0);
    step();
    idle();
    for (int c = 0; c < 3; c++) begin
      check($sformatf("cdb_wait%0d", c), 32'(res_valid), 32'd0);
      step();
    end
    cdb_valid = 1'b1;
    cdb_tag   = 3'd3;
    cdb_data  = 32'd7;
    step();
    idle();
    check("cdb_capture_latency", 32'(res_valid), 32'd0);
    step();
    check("cdb_valid",  32'(res_valid), 32'd1);
    check("cdb_tag",    32'(res_rob_tag), 32'd5);
    check("cdb_taken",  32'(res_taken), 32'd0);
    check("cdb_target", res_target, 32'h804);
    check("cdb_misp",   32'(res_mispredict), 32'd1);
    step();

    // Dispatch coinciding with the matching broadcast enqueues a valid operand.
    drive(3'b000, 32'h900, 32'h10, 3'd6, 1'b1, 1'b0, 32'd0, 3'd2, 1'b1, 32'd9, 3'd0);
    cdb_valid = 1'b1;
    cdb_tag   = 3'd2;
    cdb_data  = 32'd9;
    step();
    idle();
    step();
    check("fwd_valid",  32'(res_valid), 32'd1);
    check("fwd_taken",  32'(res_taken), 32'd1);
    check("fwd_target", res_target, 32'h910);
    step();

    // Fill the queue with pending entries (pointers start mid-ring, so they wrap).
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("fill_ready%0d", i), 32'(disp_ready), 32'd1);
      drive(3'b001, 32'h1000 + 32'(i) * 32'h10, 32'h40, 3'(i + 1), 1'b1,
            1'b0, 32'd0, 3'(i + 4), 1'b1, 32'd0, 3'd0);
      step();
    end
    idle();
    check("full_ready", 32'(disp_ready), 32'd0);
    drive(3'b000, 32'h2000, 32'h4, 3'd6, 1'b0, 1'b1, 32'd1, 3'd0, 1'b1, 32'd1, 3'd0);
    step();
    idle();
    check("full_ignored_ready", 32'(disp_ready), 32'd0);
    for (int t = 7; t >= 4; t--) begin
      cdb_valid = 1'b1;
      cdb_tag   = 3'(t);
      cdb_data  = 32'h11;
      step();
      idle();
      check($sformatf("full_hold_t%0d", t), 32'(res_valid), 32'd0);
    end
    n = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (res_valid) begin
        if (n < 4) begin
          got_tag[n] = res_rob_tag;
          got_tgt[n] = res_target;
        end
        n++;
      end
    end
    check("full_resolve_count", 32'(n), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < n) begin
        check($sformatf("full_order_tag%0d", i), 32'(got_tag[i]), 32'(i + 1));
        check($sformatf("full_order_tgt%0d", i), got_tgt[i], 32'h1040 + 32'(i) * 32'h10);
      end
    end
    check("drained_ready", 32'(disp_ready), 32'd1);

    // Flush beats a ready head and a simultaneous dispatch.
    drive(3'b000, 32'h3000, 32'h8, 3'd2, 1'b0, 1'b1, 32'd1, 3'd0, 1'b1, 32'd1, 3'd0);
    step();
    drive(3'b000, 32'h3100, 32'h8, 3'd3, 1'b0, 1'b1, 32'd1, 3'd0, 1'b1, 32'd1, 3'd0);
    flush = 1'b1;
    step();
    idle();
    check("flush_res_valid", 32'(res_valid), 32'd0);
    check("flush_ready",     32'(disp_ready), 32'd1);
    for (int c = 0; c < 4; c++) begin
      step();
      check($sformatf("flush_empty%0d", c), 32'(res_valid), 32'd0);
    end

    // Asynchronous reset with three pending entries queued.
    for (int i = 0; i < 3; i++) begin
      drive(3'b000, 32'h4000, 32'h8, 3'(i + 1), 1'b1, 1'b0, 32'd0, 3'd7, 1'b1, 32'd0, 3'd0);
      step();
    end
    idle();
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async");
    step();
    #2;
    rst = 1'b0;
    cdb_valid = 1'b1;
    cdb_tag   = 3'd7;
    cdb_data  = 32'd0;
    step();
    step();
    idle();
    for (int c = 0; c < 4; c++) begin
      check($sformatf("post_rst_stale%0d", c), 32'(res_valid), 32'd0);
      step();
    end
    drive(3'b000, 32'h5000, 32'h30, 3'd4, 1'b0, 1'b1, 32'd2, 3'd0, 1'b1, 32'd2, 3'd0);
    step();
    idle();
    step();
    check("post_rst_valid",  32'(res_valid), 32'd1);
    check("post_rst_tag",    32'(res_rob_tag), 32'd4);
    check("post_rst_target", res_target, 32'h5030);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
